// File: rtl/fsm_counter_pkg.sv
// fsm_counter_pkg: shared state encoding for the window counter FSM
package fsm_counter_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {S_IDLE, S_ARM, S_COUNT, S_DONE} fsm_state_t;
endpackage

// File: rtl/fsm_window_counter.sv
// fsm_window_counter: start/stop counter that finishes on a stop inside a runtime window
// Ports: clk, rst (async, active-high); start, stop, abort, clear controls;
//   win_lo/win_hi inclusive unsigned window; counter running count; cap_value count at stop
//   accept; state FSM state; busy in ARM/COUNT; done 1-cycle pulse; overflow sticky all-ones hit.
module fsm_window_counter
  import fsm_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             abort,
  input  logic             clear,
  input  logic [WIDTH-1:0] win_lo,
  input  logic [WIDTH-1:0] win_hi,
  output logic [WIDTH-1:0] counter,
  output logic [WIDTH-1:0] cap_value,
  output fsm_state_t       state,
  output logic             busy,
  output logic             done,
  output logic             overflow
);
  fsm_state_t state_nxt;
  logic       at_max;
  logic       accept;
  assign at_max = &counter;
  // window test uses the pre-increment count; an inverted window never matches
  assign accept = stop && counter >= win_lo && counter <= win_hi;
  assign busy   = state == S_ARM || state == S_COUNT;
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = start ? S_ARM : S_IDLE;
      S_ARM:   state_nxt = abort ? S_IDLE : S_COUNT;
      S_COUNT: state_nxt = abort ? S_IDLE : accept ? S_DONE : S_COUNT;
      S_DONE:  state_nxt = clear ? S_IDLE : S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      counter   <= '0;
      cap_value <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= state == S_COUNT && !abort && accept;
      case (state)
        S_ARM: begin
          counter  <= '0;
          overflow <= 1'b0;
        end
        S_COUNT: begin
          if (abort) counter <= '0;
          else begin
            // keeps counting on the accept cycle; capture takes the value before the step
            counter  <= at_max ? (WRAP ? '0 : counter) : counter + 1'b1;
            overflow <= overflow | at_max;
            if (accept) cap_value <= counter;
          end
        end
        S_DONE:  if (clear) counter <= '0;
        default: counter <= '0;
      endcase
    end
  end
endmodule
